// File: rtl/sdp_bram_pkg.sv
// rtl/sdp_bram_pkg.sv - shared types and width helpers for the BRAM stream reader
package sdp_bram_pkg;

  // Bits needed to hold the value 'depth' (Xilinx-style clogb2).
  function automatic int clogb2(input int depth);
    int width;
    width = 0;
    for (int d = depth; d > 0; d = d >> 1) begin
      width = width + 1;
    end
    return width;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_e;

  localparam int DEF_NB_COL    = 8;
  localparam int DEF_COL_WIDTH = 8;
  localparam int DEF_RAM_DEPTH = 512;
  localparam int DEF_ADDR_W    = clogb2(DEF_RAM_DEPTH - 1);
  localparam int DEF_DATA_W    = DEF_NB_COL * DEF_COL_WIDTH;

endpackage

// File: rtl/stream_sync_fifo.sv
// rtl/stream_sync_fifo.sv - single-clock first-word fall-through FIFO
module stream_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clkb,
  input  logic             rstb,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clkb) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clkb) begin
    if (rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdp_bram_stream_reader.sv
// rtl/sdp_bram_stream_reader.sv - burst read controller: BRAM read port to valid/ready stream
module sdp_bram_stream_reader
  import sdp_bram_pkg::*;
#(
  parameter int NB_COL       = DEF_NB_COL,
  parameter int COL_WIDTH    = DEF_COL_WIDTH,
  parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int ADDR_W      = clogb2(RAM_DEPTH - 1),
  localparam int DATA_W      = NB_COL * COL_WIDTH
) (
  input  logic              clkb,
  input  logic              rstb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_enb,
  output logic              bram_regceb,
  output logic              bram_rstb,
  input  logic [DATA_W-1:0] bram_doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              done
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IFL_W = $clog2(READ_LATENCY + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  rd_state_e               state;
  logic [ADDR_W-1:0]       issue_addr;
  logic [ADDR_W-1:0]       next_addr;
  logic [LEN_W-1:0]        issue_left;
  logic [LEN_W-1:0]        out_left;
  logic [LEN_W-1:0]        len_clamped;
  logic [READ_LATENCY-1:0] tag_sr;
  logic [IFL_W-1:0]        inflight_count;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    tag_out;
  logic                    issue;
  logic                    handshake;

  assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign next_addr   = (issue_addr == LAST_ADDR) ? '0 : issue_addr + ADDR_W'(1);

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_count = inflight_count + IFL_W'(tag_sr[i]);
    end
  end

  // Every issued read already owns a FIFO slot, so the FIFO can never overflow.
  assign issue = (state == READ) && (issue_left != '0) &&
                 ((int'(fifo_count) + int'(inflight_count)) < FIFO_DEPTH);

  assign cmd_ready   = (state == IDLE) && !rstb;
  assign bram_enb    = issue;
  assign bram_addrb  = issue_addr;
  assign bram_regceb = 1'b1;
  assign bram_rstb   = rstb;

  assign tag_out   = tag_sr[READ_LATENCY-1];
  assign m_valid   = !fifo_empty;
  assign handshake = m_valid && m_ready;
  assign m_last    = m_valid && (out_left == LEN_W'(1));

  always_ff @(posedge clkb) begin
    if (rstb) begin
      tag_sr <= '0;
    end else begin
      tag_sr <= (tag_sr << 1) | READ_LATENCY'(issue);
    end
  end

  always_ff @(posedge clkb) begin
    if (rstb) begin
      state      <= IDLE;
      done       <= 1'b0;
      issue_addr <= '0;
      issue_left <= '0;
      out_left   <= '0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        issue_addr <= next_addr;
        issue_left <= issue_left - LEN_W'(1);
      end
      if (handshake) begin
        out_left <= out_left - LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            issue_addr <= cmd_addr;
            issue_left <= len_clamped;
            out_left   <= len_clamped;
            if (len_clamped == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (issue && (issue_left == LEN_W'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (handshake && (out_left == LEN_W'(1))) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clkb) begin
    if (!rstb) begin
      assert (!(tag_out && fifo_full && !handshake));
    end
  end

  stream_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clkb  (clkb),
    .rstb  (rstb),
    .push  (tag_out),
    .din   (bram_doutb),
    .pop   (handshake),
    .dout  (m_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_sdp_bram_stream_reader.sv
// tb/tb_sdp_bram_stream_reader.sv - self-checking bench for sdp_bram_stream_reader
module tb_sdp_bram_stream_reader;
  import sdp_bram_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int LW    = DEF_ADDR_W + 1;
  localparam int DW    = DEF_DATA_W;
  localparam int DEPTH = DEF_RAM_DEPTH;
  localparam int FD    = 4;

  logic          clkb = 1'b0;
  logic          rstb;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] bram_addrb;
  logic          bram_enb;
  logic          bram_regceb;
  logic          bram_rstb;
  logic [DW-1:0] bram_doutb;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          done;

  always #5 clkb = ~clkb;

  sdp_bram_stream_reader dut (
    .clkb        (clkb),
    .rstb        (rstb),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .bram_addrb  (bram_addrb),
    .bram_enb    (bram_enb),
    .bram_regceb (bram_regceb),
    .bram_rstb   (bram_rstb),
    .bram_doutb  (bram_doutb),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .done        (done)
  );

  // Two-stage BRAM read model: array latch then output register.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] bram_q1;
  always @(posedge clkb) begin
    if (bram_enb) bram_q1 <= mem[bram_addrb];
    if (bram_rstb) bram_doutb <= '0;
    else if (bram_regceb) bram_doutb <= bram_q1;
  end

  int tests_run = 0;
  int fails = 0;
  int neg_cyc = 0;
  int ready_mode = 0;
  int ph = 0;
  logic [DW-1:0] got_q[$], exp_q[$];
  logic          got_last_q[$], exp_last_q[$];
  int            hs_cyc_q[$], enb_addr_q[$], exp_addr_q[$];
  int            enb_cnt, valid_cnt, done_cnt, done_cyc, issued, popped;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // m_ready driver: 0 always, 1 one-high-three-low, 2 random, 3 held low
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clkb); #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = (ph % 4 == 0); ph++; end
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Observer: samples mid-cycle, so a recorded handshake commits on the next edge.
  always @(negedge clkb) begin
    neg_cyc++;
    if (rstb) begin
      issued = 0;
      popped = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk_w("stall_data", m_data, prev_data);
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid) valid_cnt++;
      if (bram_enb) begin
        issued++;
        enb_cnt++;
        enb_addr_q.push_back(int'(bram_addrb));
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
        hs_cyc_q.push_back(neg_cyc);
        popped++;
      end
      if (bram_enb) chk("credit", 32'(issued - popped <= FD), 32'd1);
      if (done) begin
        done_cnt++;
        done_cyc = neg_cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic clear_obs();
    got_q.delete(); got_last_q.delete(); hs_cyc_q.delete(); enb_addr_q.delete();
    exp_q.delete(); exp_last_q.delete(); exp_addr_q.delete();
    enb_cnt = 0; valid_cnt = 0; done_cnt = 0; done_cyc = -1; issued = 0; popped = 0;
  endtask

  // Reference: a burst is min(len, DEPTH) consecutive words, addresses modulo DEPTH.
  task automatic model(input int addr, input int len);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mem[(addr + k) % DEPTH]);
      exp_last_q.push_back(k == n - 1);
      exp_addr_q.push_back((addr + k) % DEPTH);
    end
  endtask

  task automatic send_cmd(input int addr, input int len, output int acc);
    int n;
    @(posedge clkb); #1;
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    acc = -1;
    n = 0;
    while (acc < 0 && n < 200) begin
      @(negedge clkb); #1;
      if (cmd_ready) acc = neg_cyc;
      n++;
    end
    chk("cmd_accept", 32'(acc >= 0), 32'd1);
    @(posedge clkb); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int n;
    n = 0;
    while (done_cnt < target && n < bound) begin
      @(negedge clkb); #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_words"}, got_q.size(), exp_q.size());
    chk({tag, "_issues"}, enb_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk_w($sformatf("%s_data%0d", tag, i), got_q[i], exp_q[i]);
        chk($sformatf("%s_last%0d", tag, i), 32'(got_last_q[i]), 32'(exp_last_q[i]));
      end
      if (i < enb_addr_q.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), enb_addr_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic run_burst(input int addr, input int len, input int mode, input string tag);
    int acc;
    int n;
    clear_obs();
    ready_mode = mode;
    model(addr, len);
    n = exp_q.size();
    send_cmd(addr, len, acc);
    wait_done(1, 8 * n + 60);
    check_stream(tag);
    if (n == 0) begin
      chk({tag, "_zero_done_cyc"}, done_cyc, acc + 1);
      chk({tag, "_zero_valid"}, valid_cnt, 0);
    end else if (hs_cyc_q.size() > 0) begin
      chk({tag, "_done_cyc"}, done_cyc, hs_cyc_q[$] + 1);
      if (mode == 0) begin
        chk({tag, "_first_lat"}, hs_cyc_q[0], acc + 4);
        chk({tag, "_back2back"}, hs_cyc_q[$] - hs_cyc_q[0], n - 1);
      end
    end
    @(negedge clkb); #1;
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int acc_a;
    int acc_b;
    int n;
    rstb = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    clear_obs();

    repeat (3) @(posedge clkb);
    @(negedge clkb); #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_enb", 32'(bram_enb), 32'd0);
    chk("rst_addrb", 32'(bram_addrb), 32'd0);
    @(posedge clkb); #1;
    rstb = 1'b0;
    @(negedge clkb); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    run_burst(10, 8, 0, "basic");
    run_burst(510, 4, 0, "wrap");
    run_burst(20, 16, 1, "bp");
    run_burst(7, 0, 0, "zero");

    // Reset in the middle of a stalled burst
    clear_obs();
    ready_mode = 0;
    model(40, 32);
    send_cmd(40, 32, acc_a);
    n = 0;
    while (got_q.size() < 5 && n < 100) begin
      @(negedge clkb); #1;
      n++;
    end
    ready_mode = 3;
    @(posedge clkb);
    repeat (4) @(posedge clkb);
    #1 rstb = 1'b1;
    @(posedge clkb); #1;
    rstb = 1'b0;
    chk("midrst_words", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      chk_w($sformatf("midrst_data%0d", i), got_q[i], exp_q[i]);
    end
    ready_mode = 0;
    repeat (6) begin
      @(negedge clkb); #1;
      chk("midrst_no_valid", 32'(m_valid), 32'd0);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    run_burst(0, 2, 0, "post_rst");

    // Second command waits behind the first until FINISH has passed
    clear_obs();
    ready_mode = 0;
    model(0, 3);
    model(100, 3);
    send_cmd(0, 3, acc_a);
    send_cmd(100, 3, acc_b);
    chk("b2b_a_done_first", done_cnt, 1);
    chk("b2b_b_accept", acc_b, done_cyc + 1);
    wait_done(2, 100);
    check_stream("b2b");
    chk("b2b_b_done_cyc", done_cyc, hs_cyc_q.size() > 0 ? hs_cyc_q[$] + 1 : -2);
    @(negedge clkb); #1;
    chk("b2b_done_count", done_cnt, 2);

    run_burst(300, 700, 0, "clamp");

    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    for (int r = 0; r < 12; r++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 2)), $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
